// File: rtl/edge_event_arbiter.sv
// Per-channel edge capture with a one-deep pending store, serialized onto a single
// valid/ready event port by a round-robin scheduler.
module edge_event_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_CH-1:0]  in_bits_i,
    input  logic             evt_ready_i,
    input  logic             ovf_clr_i,
    output logic             evt_valid_o,
    output logic [IDX_W-1:0] evt_ch_o,
    output logic             evt_level_o,
    output logic [N_CH-1:0]  ovf_o
);

    // state | meaning
    // IDLE  | no event offered; loads the round-robin winner if any channel is pending
    // OFFER | event held stable on the port until evt_ready_i completes the transfer
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(N_CH - 1);

    state_e           state_q;
    logic [N_CH-1:0]  prev_q;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  plvl_q, plvl_d;
    logic [N_CH-1:0]  ovf_q, ovf_d;
    logic [IDX_W-1:0] ptr_q;
    logic             evt_valid_q;
    logic [IDX_W-1:0] evt_ch_q;
    logic             evt_level_q;

    logic [N_CH-1:0]  edge_det;
    logic [N_CH-1:0]  ovf_set;
    logic [IDX_W:0]   idx_sum;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] ptr_nxt;
    logic             found;
    logic             load;

    assign edge_det = in_bits_i ^ prev_q;

    // Scan from the farthest candidate back to ptr so the closest pending channel wins last.
    always_comb begin
        win     = '0;
        found   = 1'b0;
        idx_sum = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx_sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (idx_sum >= (IDX_W + 1)'(N_CH)) begin
                idx_sum = idx_sum - (IDX_W + 1)'(N_CH);
            end
            if (pend_q[idx_sum[IDX_W-1:0]]) begin
                win   = idx_sum[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign load    = (state_q == IDLE) && found;
    assign ptr_nxt = (win == LAST_CH) ? '0 : win + IDX_W'(1);

    // A fresh edge always re-arms the channel, even on the cycle its old event is loaded.
    always_comb begin
        pend_d  = pend_q;
        plvl_d  = plvl_q;
        ovf_set = '0;
        for (int i = 0; i < N_CH; i++) begin
            pend_d[i]  = edge_det[i] | (pend_q[i] & ~(load && (win == IDX_W'(i))));
            plvl_d[i]  = edge_det[i] ? in_bits_i[i] : plvl_q[i];
            ovf_set[i] = edge_det[i] & pend_q[i] & ~(load && (win == IDX_W'(i)));
        end
        ovf_d = (ovf_clr_i ? '0 : ovf_q) | ovf_set;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            pend_q      <= '0;
            plvl_q      <= '0;
            ovf_q       <= '0;
            ptr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_level_q <= 1'b0;
        end else begin
            prev_q <= in_bits_i;
            pend_q <= pend_d;
            plvl_q <= plvl_d;
            ovf_q  <= ovf_d;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        evt_valid_q <= 1'b1;
                        evt_ch_q    <= win;
                        evt_level_q <= plvl_q[win];
                        ptr_q       <= ptr_nxt;
                        state_q     <= OFFER;
                    end else begin
                        evt_valid_q <= 1'b0;
                    end
                end
                OFFER: begin
                    if (evt_ready_i) begin
                        evt_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    evt_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_ch_o    = evt_ch_q;
    assign evt_level_o = evt_level_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: inputs driven and outputs sampled on the
// falling clock edge, expected values hand-computed per step.
module tb_edge_event_arbiter;

    logic       clk_i;
    logic       rst_n_i;
    logic [3:0] in_bits_i;
    logic       evt_ready_i;
    logic       ovf_clr_i;
    logic       evt_valid_o;
    logic [1:0] evt_ch_o;
    logic       evt_level_o;
    logic [3:0] ovf_o;

    int n_checks = 0;
    int n_errors = 0;

    edge_event_arbiter #(.N_CH(4), .IDX_W(2)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_bits_i   (in_bits_i),
        .evt_ready_i (evt_ready_i),
        .ovf_clr_i   (ovf_clr_i),
        .evt_valid_o (evt_valid_o),
        .evt_ch_o    (evt_ch_o),
        .evt_level_o (evt_level_o),
        .ovf_o       (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_evt(input string tag, input logic [1:0] ch, input logic lvl);
        chk({tag, "_valid"}, 32'(evt_valid_o), 32'd1);
        chk({tag, "_ch"},    32'(evt_ch_o),    32'(ch));
        chk({tag, "_lvl"},   32'(evt_level_o), 32'(lvl));
    endtask

    task automatic nstep();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_n_i   = 1'b0;
        in_bits_i = 4'b0000;
        nstep();
        rst_n_i = 1'b1;
        nstep();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ord_a [4];
        logic [1:0] ord_b [2];
        ord_a[0] = 2'd0; ord_a[1] = 2'd1; ord_a[2] = 2'd2; ord_a[3] = 2'd3;
        ord_b[0] = 2'd1; ord_b[1] = 2'd3;

        // reset values
        rst_n_i     = 1'b0;
        in_bits_i   = 4'b0000;
        evt_ready_i = 1'b1;
        ovf_clr_i   = 1'b0;
        #12;
        chk("rst_valid", 32'(evt_valid_o), 32'd0);
        chk("rst_ch",    32'(evt_ch_o),    32'd0);
        chk("rst_lvl",   32'(evt_level_o), 32'd0);
        chk("rst_ovf",   32'(ovf_o),       32'd0);
        nstep();
        rst_n_i = 1'b1;
        nstep();
        nstep();
        chk("idle_valid", 32'(evt_valid_o), 32'd0);

        // single rising edge on ch2: valid after E1, drops at E2
        in_bits_i = 4'b0100;
        nstep();
        chk("t1_e0_valid", 32'(evt_valid_o), 32'd0);
        nstep();
        chk_evt("t1_e1", 2'd2, 1'b1);
        nstep();
        chk("t1_e2_valid", 32'(evt_valid_o), 32'd0);
        chk("t1_ovf",      32'(ovf_o),       32'd0);

        // all four rise together: served 0,1,2,3 every other cycle
        do_reset();
        in_bits_i = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            nstep();
            if (k % 2 == 1) chk_evt($sformatf("t2_ev%0d", k / 2), ord_a[k / 2], 1'b1);
            else            chk($sformatf("t2_gap%0d", k), 32'(evt_valid_o), 32'd0);
        end
        nstep();
        chk("t2_quiet", 32'(evt_valid_o), 32'd0);

        // ch1 and ch3 fall together; ptr back at 0 so ch1 goes first
        in_bits_i = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            nstep();
            if (k % 2 == 1) chk_evt($sformatf("t2b_ev%0d", k / 2), ord_b[k / 2], 1'b0);
            else            chk($sformatf("t2b_gap%0d", k), 32'(evt_valid_o), 32'd0);
        end

        // stalled offer on ch1 while ch1 toggles twice -> overflow, offer stable
        evt_ready_i = 1'b0;
        in_bits_i   = 4'b0111;
        nstep();
        chk("t3_e0_valid", 32'(evt_valid_o), 32'd0);
        nstep();
        chk_evt("t3_e1", 2'd1, 1'b1);
        in_bits_i = 4'b0101;
        nstep();
        chk_evt("t3_e2", 2'd1, 1'b1);
        chk("t3_e2_ovf", 32'(ovf_o), 32'd0);
        in_bits_i = 4'b0111;
        nstep();
        chk_evt("t3_e3", 2'd1, 1'b1);
        chk("t3_e3_ovf", 32'(ovf_o), 32'b0010);
        evt_ready_i = 1'b1;
        nstep();
        chk("t3_e4_valid", 32'(evt_valid_o), 32'd0);
        nstep();
        chk_evt("t3_e5", 2'd1, 1'b1);
        nstep();
        chk("t3_e6_valid", 32'(evt_valid_o), 32'd0);

        // ptr now 2: ch0 and ch3 pending together -> ch3 first, then ch0
        in_bits_i = 4'b1110;
        nstep();
        chk("t4_e0_valid", 32'(evt_valid_o), 32'd0);
        nstep();
        chk_evt("t4_first", 2'd3, 1'b1);
        nstep();
        chk("t4_gap", 32'(evt_valid_o), 32'd0);
        nstep();
        chk_evt("t4_second", 2'd0, 1'b0);
        nstep();
        chk("t4_end_valid", 32'(evt_valid_o), 32'd0);

        // clear old overflow
        ovf_clr_i = 1'b1;
        nstep();
        ovf_clr_i = 1'b0;
        chk("t5_clr", 32'(ovf_o), 32'd0);

        // edge on the channel being loaded: edge wins, no overflow
        evt_ready_i = 1'b0;
        in_bits_i   = 4'b0110;
        nstep();
        chk("t5_e0_valid", 32'(evt_valid_o), 32'd0);
        in_bits_i = 4'b1110;
        nstep();
        chk_evt("t5_e1", 2'd3, 1'b0);
        chk("t5_e1_ovf", 32'(ovf_o), 32'd0);
        in_bits_i = 4'b0110;
        nstep();
        chk("t5_e2_ovf", 32'(ovf_o), 32'b1000);
        chk_evt("t5_e2", 2'd3, 1'b0);
        in_bits_i = 4'b0111;
        nstep();
        // new overflow on ch0 in the same cycle as the clear
        in_bits_i = 4'b0110;
        ovf_clr_i = 1'b1;
        nstep();
        ovf_clr_i = 1'b0;
        chk("t5_clr_vs_set", 32'(ovf_o), 32'b0001);

        // async reset mid-offer with ch0, ch1, ch3 pending
        in_bits_i = 4'b0100;
        nstep();
        chk("t6_pre_valid", 32'(evt_valid_o), 32'd1);
        #2;
        rst_n_i   = 1'b0;
        in_bits_i = 4'b0000;
        #1;
        chk("t6_async_valid", 32'(evt_valid_o), 32'd0);
        chk("t6_async_ch",    32'(evt_ch_o),    32'd0);
        chk("t6_async_ovf",   32'(ovf_o),       32'd0);
        nstep();
        rst_n_i     = 1'b1;
        evt_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            nstep();
            chk($sformatf("t6_stale%0d", k), 32'(evt_valid_o), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
